muldiv_unit: RTL

Iterative signed multiply/divide unit. It consumes the 4-bit ALU control codes for mult (4'b1010) and div (4'b1011) and executes them over multiple cycles into HI/LO registers. It sits beside the single-cycle ALU in the datapath, and the controller stalls on busy. It is the execution-side consumer of the ALU-control decode for the long-latency operations.

---
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the datapath controller and the iterative
// multiply/divide unit; the controller uses master, the unit uses slave.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       alucontrol;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             divzero;

    modport master (
        output start, alucontrol, a, b,
        input  busy, done, hi, lo, divzero
    );

    modport slave (
        input  start, alucontrol, a, b,
        output busy, done, hi, lo, divzero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) into HI/LO.
// Define MULDIV_UNSIGNED_EN to also accept multu (4'b1100) and divu (4'b1101).
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           reset,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   divzero_q, divzero_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic                   is_div_q, is_div_d;
    logic                   dz_q, dz_d;
    logic                   sa_q, sa_d;
    logic                   sb_q, sb_d;
    logic [WIDTH-1:0]       amag_q, amag_d;
    logic [WIDTH-1:0]       bmag_q, bmag_d;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]       acc_hi;
    logic [WIDTH-1:0]       acc_lo;
    logic [WIDTH:0]         sum;
    logic [WIDTH:0]         shifted;
    logic [WIDTH:0]         diff;
    logic [2*WIDTH-1:0]     prod;
    logic                   unsigned_op;

    assign a_s    = bus.a;
    assign b_s    = bus.b;
    assign acc_hi = acc_q[2*WIDTH-1:WIDTH];
    assign acc_lo = acc_q[WIDTH-1:0];

    // -2^(W-1) maps to the unsigned value 2^(W-1), which still fits in W bits.
    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? $unsigned(-x) : $unsigned(x);
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic neg, input logic [WIDTH-1:0] x);
        return neg ? -x : x;
    endfunction

    function automatic logic op_ok(input logic [3:0] code);
`ifdef MULDIV_UNSIGNED_EN
        return (code == 4'b1010) || (code == 4'b1011) || (code == 4'b1100) || (code == 4'b1101);
`else
        return (code == 4'b1010) || (code == 4'b1011);
`endif
    endfunction

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        divzero_d   = 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        is_div_d    = is_div_q;
        dz_d        = dz_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        amag_d      = amag_q;
        bmag_d      = bmag_q;
        sum         = '0;
        shifted     = '0;
        diff        = '0;
        prod        = '0;
        unsigned_op = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start && op_ok(bus.alucontrol)) begin
`ifdef MULDIV_UNSIGNED_EN
                    unsigned_op = bus.alucontrol[2];
`endif
                    // Unsigned ops clear the signs so the SIGN step becomes a pass-through.
                    is_div_d = bus.alucontrol[0];
                    sa_d     = !unsigned_op && a_s[WIDTH-1];
                    sb_d     = !unsigned_op && b_s[WIDTH-1];
                    amag_d   = unsigned_op ? bus.a : mag(a_s);
                    bmag_d   = unsigned_op ? bus.b : mag(b_s);
                    dz_d     = (bus.b == '0);
                    cnt_d    = '0;
                    acc_d    = {{WIDTH{1'b0}}, (bus.alucontrol[0] ? amag_d : bmag_d)};
                    busy_d   = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (is_div_q) begin
                    // Restoring step: acc_hi is the partial remainder, acc_lo the quotient.
                    shifted = {acc_hi, acc_lo[WIDTH-1]};
                    diff    = shifted - {1'b0, bmag_q};
                    if (!diff[WIDTH])
                        acc_d = {diff[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {shifted[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
                end else begin
                    sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, amag_q} : {(WIDTH+1){1'b0}});
                    acc_d = {sum, acc_lo[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST)
                    state_d = SIGN;
            end
            SIGN: begin
                if (is_div_q) begin
                    if (dz_q) begin
                        hi_d      = apply_sign(sa_q, amag_q);
                        lo_d      = '1;
                        divzero_d = 1'b1;
                    end else begin
                        hi_d = apply_sign(sa_q, acc_hi);
                        lo_d = apply_sign(sa_q ^ sb_q, acc_lo);
                    end
                end else begin
                    prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        cnt_q    <= cnt_d;
        acc_q    <= acc_d;
        is_div_q <= is_div_d;
        dz_q     <= dz_d;
        sa_q     <= sa_d;
        sb_q     <= sb_d;
        amag_q   <= amag_d;
        bmag_q   <= bmag_d;
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.divzero = divzero_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
endmodule
